// File: rtl/pipemem_pkg.sv
// Shared types and helpers for the pipelined Wishbone memory unit:
// access-size encodings, the tag carried per outstanding request, and the
// byte-select / lane functions (big-endian lanes: sel[3] is byte offset 0).
package pipemem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam int unsigned TAG_W = 5 + 2 + 2;

  typedef struct packed {
    logic [4:0] oreg;
    size_e      size;
    logic [1:0] lsb;
  } tag_t;

  // Byte selects for an access; reserved size behaves as a word.
  function automatic logic [3:0] sel_gen(input size_e size, input logic [1:0] lsb);
    logic [3:0] sel;
    case (size)
      SZ_HALF: sel = lsb[1] ? 4'b0011 : 4'b1100;
      SZ_BYTE: sel = 4'b1000 >> lsb;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Store data replicated across every lane it may land in.
  function automatic logic [31:0] store_data(input size_e size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_HALF: r = {2{d[15:0]}};
      SZ_BYTE: r = {4{d[7:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Zero-extended load data picked from the lane the request addressed.
  function automatic logic [31:0] lane_extract(input size_e size, input logic [1:0] lsb,
                                               input logic [31:0] data);
    logic [31:0] r;
    logic [31:0] sh;
    sh = data >> {~lsb, 3'b000};
    case (size)
      SZ_HALF: r = lsb[1] ? {16'h0000, data[15:0]} : {16'h0000, data[31:16]};
      SZ_BYTE: r = {24'h000000, sh[7:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] lsb);
    logic m;
    case (size)
      SZ_HALF: m = lsb[0];
      SZ_BYTE: m = 1'b0;
      default: m = (lsb != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pipemem_tagfifo.sv
// Tag FIFO holding one entry per outstanding bus request. Depth 2^LGFIFO,
// pointers wrap naturally; flush empties it in one clock.
module pipemem_tagfifo #(
  parameter int unsigned LGFIFO = 4,
  parameter int unsigned W      = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [W-1:0]      push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [W-1:0]      head,
  output logic              full,
  output logic              empty,
  output logic [LGFIFO:0]   count
);

  logic [W-1:0]        mem [2**LGFIFO];
  logic [LGFIFO-1:0]   wr_ptr;
  logic [LGFIFO-1:0]   rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = count[LGFIFO];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage; no reset needed since only pushed entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LGFIFO'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LGFIFO'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (LGFIFO+1)'(1);
        2'b01:   count <= count - (LGFIFO+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipemem_sized.sv
// Pipelined Wishbone memory unit: one load/store per clock to either the
// global bus or the local peripheral window, byte/half/word via o_wb_sel.
// Optional build macro PIPEMEM_LOCK_EN keeps the cycle line held while
// i_lock is high; without it i_lock is ignored.
module pipemem_sized
  import pipemem_pkg::*;
#(
  parameter int unsigned AW       = 30,
  parameter int unsigned LGFIFO   = 4,
  parameter logic [31:0] LCL_BASE = 32'hc0000000,
  parameter logic [31:0] LCL_MASK = 32'hffffffe0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_stb,
  input  logic          i_lock,
  input  logic [2:0]    i_op,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_data,
  input  logic [4:0]    i_oreg,
  output logic          o_busy,
  output logic          o_pipe_stalled,
  output logic          o_valid,
  output logic          o_err,
  output logic [4:0]    o_wreg,
  output logic [31:0]   o_result,
  output logic          o_wb_cyc_gbl,
  output logic          o_wb_cyc_lcl,
  output logic          o_wb_stb_gbl,
  output logic          o_wb_stb_lcl,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  size_e             req_size;
  logic              req_lcl;
  logic              req_misaligned;
  logic              stb_any;
  logic              accept;
  logic              bus_err;
  logic              push;
  logic              pop;
  logic              drained;
  logic              lock_hold;
  tag_t              push_entry;
  tag_t              head_tag;
  logic [TAG_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LGFIFO:0]   fifo_count;

`ifdef PIPEMEM_LOCK_EN
  assign lock_hold = i_lock;
`else
  logic unused_lock;
  assign unused_lock = i_lock;
  assign lock_hold   = 1'b0;
`endif

  assign req_size       = size_e'(i_op[2:1]);
  assign req_lcl        = (((i_addr ^ LCL_BASE) & LCL_MASK) == '0);
  assign req_misaligned = misaligned(req_size, i_addr[1:0]);
  assign o_busy         = o_wb_cyc_gbl | o_wb_cyc_lcl;
  assign stb_any        = o_wb_stb_gbl | o_wb_stb_lcl;

  // Back-pressure toward the CPU; never stalls while the bus is idle.
  always_comb begin
    o_pipe_stalled = 1'b0;
    if (o_busy)
      o_pipe_stalled = (stb_any && i_wb_stall) || fifo_full
                    || (i_op[0] != o_wb_we) || (req_lcl != o_wb_cyc_lcl)
                    || req_misaligned;
  end

  assign accept  = i_stb && !o_pipe_stalled;
  assign bus_err = i_wb_err && o_busy;
  assign push    = accept && !req_misaligned && !bus_err;
  assign pop     = i_wb_ack && o_busy && !i_wb_err && !fifo_empty;
  // Nothing left outstanding after this clock and nothing new arriving.
  assign drained = !push && (fifo_empty || (pop && fifo_count == (LGFIFO+1)'(1)));

  assign push_entry = '{oreg: i_oreg, size: req_size, lsb: i_addr[1:0]};
  assign head_tag   = tag_t'(fifo_head);

  pipemem_tagfifo #(
    .LGFIFO (LGFIFO),
    .W      (TAG_W)
  ) u_tagfifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus_err),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Cycle/strobe control: error aborts, new requests (re)assert, completion releases.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_cyc_gbl <= 1'b0;
      o_wb_cyc_lcl <= 1'b0;
      o_wb_stb_gbl <= 1'b0;
      o_wb_stb_lcl <= 1'b0;
    end else if (bus_err) begin
      o_wb_cyc_gbl <= 1'b0;
      o_wb_cyc_lcl <= 1'b0;
      o_wb_stb_gbl <= 1'b0;
      o_wb_stb_lcl <= 1'b0;
    end else if (push) begin
      o_wb_cyc_gbl <= !req_lcl;
      o_wb_cyc_lcl <= req_lcl;
      o_wb_stb_gbl <= !req_lcl;
      o_wb_stb_lcl <= req_lcl;
    end else begin
      if (!i_wb_stall) begin
        o_wb_stb_gbl <= 1'b0;
        o_wb_stb_lcl <= 1'b0;
      end
      if (o_busy && drained && !lock_hold) begin
        o_wb_cyc_gbl <= 1'b0;
        o_wb_cyc_lcl <= 1'b0;
        o_wb_stb_gbl <= 1'b0;
        o_wb_stb_lcl <= 1'b0;
      end
    end
  end

  // Request fields presented to the slave, captured on each issued request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_sel  <= '0;
    end else if (push) begin
      o_wb_we   <= i_op[0];
      o_wb_addr <= i_addr[AW+1:2];
      o_wb_data <= store_data(req_size, i_data);
      o_wb_sel  <= sel_gen(req_size, i_addr[1:0]);
    end
  end

  // Load return and error pulses toward the CPU.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_wreg   <= '0;
      o_result <= '0;
    end else begin
      o_valid <= pop && !o_wb_we;
      o_err   <= bus_err || (accept && req_misaligned);
      if (pop && !o_wb_we) begin
        o_wreg   <= head_tag.oreg;
        o_result <= lane_extract(head_tag.size, head_tag.lsb, i_wb_data);
      end
    end
  end

endmodule
